// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Purpose : one side of the ID/EX pipeline register handshake. It carries a
//           valid/ready pair plus the decoded instruction payload. The same
//           interface type is used on the decode side and on the execute side.
// Signals : valid      - producer presents an entry
//           ready      - consumer can take the entry
//           wregen     - register write enable
//           wmemen     - memory write enable
//           r1out      - operand 1      (DATA_WIDTH)
//           r2out      - operand 2      (DATA_WIDTH)
//           wreg1      - destination    (REG_ADDR_WIDTH)
//           aluopcode  - ALU operation  (ALUOP_WIDTH)
// Modports: master drives valid + payload and samples ready;
//           slave samples valid + payload and drives ready.
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUOP_WIDTH    = 4
);
  logic                      valid;
  logic                      ready;
  logic                      wregen;
  logic                      wmemen;
  logic [DATA_WIDTH-1:0]     r1out;
  logic [DATA_WIDTH-1:0]     r2out;
  logic [REG_ADDR_WIDTH-1:0] wreg1;
  logic [ALUOP_WIDTH-1:0]    aluopcode;

  modport master (
    output valid, wregen, wmemen, r1out, r2out, wreg1, aluopcode,
    input  ready
  );

  modport slave (
    input  valid, wregen, wmemen, r1out, r2out, wreg1, aluopcode,
    output ready
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Purpose : ID/EX pipeline register with valid/ready handshakes on both sides,
//           a two-entry (main + skid) buffer so the upstream ready is a flop,
//           a synchronous flush that inserts a bubble, and a saturating counter
//           of cycles in which execute stalls a valid entry.
// Ports   : clk        - clock, all state changes on the rising edge
//           reset      - synchronous active-high reset
//           flush      - synchronous kill of every in-flight entry
//           id         - decode-side handshake + payload (slave)
//           ex         - execute-side handshake + payload (master)
//           stall_cnt  - cycles with ex.valid=1 and ex.ready=0, saturating
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int ALUOP_WIDTH     = 4,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  id_ex_pipe_reg_if.slave            id,
  id_ex_pipe_reg_if.master           ex,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  typedef struct packed {
    logic                      wregen;
    logic                      wmemen;
    logic [DATA_WIDTH-1:0]     r1out;
    logic [DATA_WIDTH-1:0]     r2out;
    logic [REG_ADDR_WIDTH-1:0] wreg1;
    logic [ALUOP_WIDTH-1:0]    aluopcode;
  } payload_t;

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE =
    {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                       r_main_valid;
  payload_t                   r_main;
  logic                       r_skid_valid;
  payload_t                   r_skid;
  logic                       r_id_ready;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  logic                       w_accept;
  logic                       w_issue;
  payload_t                   w_in;
  logic                       w_main_valid_nxt;
  payload_t                   w_main_nxt;
  logic                       w_skid_valid_nxt;
  payload_t                   w_skid_nxt;
  logic [STALL_CNT_WIDTH-1:0] w_stall_nxt;

  assign w_accept = id.valid & id.ready;
  assign w_issue  = r_main_valid & ex.ready;

  assign w_in.wregen    = id.wregen;
  assign w_in.wmemen    = id.wmemen;
  assign w_in.r1out     = id.r1out;
  assign w_in.r2out     = id.r2out;
  assign w_in.wreg1     = id.wreg1;
  assign w_in.aluopcode = id.aluopcode;

  // The flop is preset to 1 in reset; the gate keeps the port low until
  // reset drops, so ready appears in the very first cycle after reset.
  assign id.ready = r_id_ready & ~reset;

  // Enables are qualified with valid so a bubble never writes anything.
  assign ex.valid     = r_main_valid;
  assign ex.wregen    = r_main_valid & r_main.wregen;
  assign ex.wmemen    = r_main_valid & r_main.wmemen;
  assign ex.r1out     = r_main.r1out;
  assign ex.r2out     = r_main.r2out;
  assign ex.wreg1     = r_main.wreg1;
  assign ex.aluopcode = r_main.aluopcode;
  assign stall_cnt    = r_stall_cnt;

  // Next-state of main/skid entries and stall counter (flush outranks data movement).
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_nxt       = r_main;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_nxt       = r_skid;
    w_stall_nxt      = r_stall_cnt;
    if (flush) begin
      // Payload is kept; only the valid bits are killed.
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      if (r_skid_valid) begin
        // id.ready is low while skid is full, so no accept can happen here.
        if (w_issue) begin
          w_main_valid_nxt = 1'b1;
          w_main_nxt       = r_skid;
          w_skid_valid_nxt = 1'b0;
        end else begin
          w_main_valid_nxt = r_main_valid;
        end
      end else if (!r_main_valid || w_issue) begin
        w_main_valid_nxt = w_accept;
        if (w_accept) begin
          w_main_nxt = w_in;
        end else begin
          w_main_nxt = r_main;
        end
      end else if (w_accept) begin
        // Main is blocked: park the younger entry in skid.
        w_skid_valid_nxt = 1'b1;
        w_skid_nxt       = w_in;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end

      if (r_main_valid && !ex.ready && (r_stall_cnt != STALL_MAX)) begin
        w_stall_nxt = r_stall_cnt + STALL_ONE;
      end else begin
        w_stall_nxt = r_stall_cnt;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_id_ready   <= 1'b1;
      r_stall_cnt  <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main       <= w_main_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_id_ready   <= ~w_skid_valid_nxt;
      r_stall_cnt  <= w_stall_nxt;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic clk;
  logic reset;
  logic flush;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  int n_vec;
  int n_err;

  id_ex_pipe_reg_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) id_a ();
  id_ex_pipe_reg_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) ex_a ();
  id_ex_pipe_reg_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) id_b ();
  id_ex_pipe_reg_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) ex_b ();

  id_ex_pipe_reg #(
    .DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4), .STALL_CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .id(id_a.slave), .ex(ex_a.master), .stall_cnt(stall_a)
  );

  // Narrow-counter copy fed with identical stimulus for the saturation check.
  id_ex_pipe_reg #(
    .DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4), .STALL_CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .id(id_b.slave), .ex(ex_b.master), .stall_cnt(stall_b)
  );

  assign id_b.valid     = id_a.valid;
  assign id_b.wregen    = id_a.wregen;
  assign id_b.wmemen    = id_a.wmemen;
  assign id_b.r1out     = id_a.r1out;
  assign id_b.r2out     = id_a.r2out;
  assign id_b.wreg1     = id_a.wreg1;
  assign id_b.aluopcode = id_a.aluopcode;
  assign ex_b.ready     = ex_a.ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic me,
                       input logic [63:0] r1, input logic [4:0] wr);
    id_a.valid     = v;
    id_a.wregen    = we;
    id_a.wmemen    = me;
    id_a.r1out     = r1;
    id_a.r2out     = ~r1;
    id_a.wreg1     = wr;
    id_a.aluopcode = 4'h5;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    ex_a.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'hAA, 5'd1);

    // Reset held two cycles with id_valid=1
    step();
    chk("rst_id_ready", {63'd0, id_a.ready}, 64'd0);
    step();
    chk("rst_id_ready2", {63'd0, id_a.ready}, 64'd0);
    chk("rst_ex_valid", {63'd0, ex_a.valid}, 64'd0);
    chk("rst_ex_wregen", {63'd0, ex_a.wregen}, 64'd0);
    chk("rst_ex_wmemen", {63'd0, ex_a.wmemen}, 64'd0);
    chk("rst_ex_r1out", ex_a.r1out, 64'd0);
    chk("rst_ex_r2out", ex_a.r2out, 64'd0);
    chk("rst_ex_wreg1", {59'd0, ex_a.wreg1}, 64'd0);
    chk("rst_ex_aluop", {60'd0, ex_a.aluopcode}, 64'd0);
    chk("rst_stall", {48'd0, stall_a}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 5'd0);
    #1;
    chk("post_rst_id_ready", {63'd0, id_a.ready}, 64'd1);
    step();
    chk("idle_ex_valid", {63'd0, ex_a.valid}, 64'd0);

    // Streaming 0x11..0x44 with ex_ready=1
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'(i * 'h11), 5'(i));
      step();
      chk("stream_valid", {63'd0, ex_a.valid}, 64'd1);
      chk("stream_r1out", ex_a.r1out, 64'(i * 'h11));
      chk("stream_r2out", ex_a.r2out, ~64'(i * 'h11));
      chk("stream_id_ready", {63'd0, id_a.ready}, 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0, 5'd0);
    step();
    chk("stream_drain", {63'd0, ex_a.valid}, 64'd0);
    chk("stream_stall", {48'd0, stall_a}, 64'd0);

    // Stall: A (wreg1=3) then B (wreg1=7) while ex_ready=0
    ex_a.ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 64'hA, 5'd3);
    step();
    chk("stall_a_wreg1", {59'd0, ex_a.wreg1}, 64'd3);
    chk("stall_a_ready", {63'd0, id_a.ready}, 64'd1);
    chk("stall_a_cnt", {48'd0, stall_a}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'hB, 5'd7);
    step();
    chk("stall_b_ready", {63'd0, id_a.ready}, 64'd0);
    chk("stall_b_wreg1", {59'd0, ex_a.wreg1}, 64'd3);
    chk("stall_b_cnt", {48'd0, stall_a}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 5'd0);
    step();
    chk("stall_hold_wreg1", {59'd0, ex_a.wreg1}, 64'd3);
    chk("stall_hold_ready", {63'd0, id_a.ready}, 64'd0);
    chk("stall_hold_cnt", {48'd0, stall_a}, 64'd2);
    ex_a.ready = 1'b1;
    #1;
    chk("release_wreg1_a", {59'd0, ex_a.wreg1}, 64'd3);
    step();
    chk("release_wreg1_b", {59'd0, ex_a.wreg1}, 64'd7);
    chk("release_r1out_b", ex_a.r1out, 64'hB);
    chk("release_valid", {63'd0, ex_a.valid}, 64'd1);
    chk("release_ready", {63'd0, id_a.ready}, 64'd1);
    chk("release_cnt", {48'd0, stall_a}, 64'd2);
    step();
    chk("release_drain", {63'd0, ex_a.valid}, 64'd0);

    // Flush with main and skid both full
    ex_a.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 64'hC, 5'd9);
    step();
    chk("fl_c_wregen", {63'd0, ex_a.wregen}, 64'd1);
    chk("fl_c_wmemen", {63'd0, ex_a.wmemen}, 64'd1);
    drive(1'b1, 1'b0, 1'b1, 64'hD, 5'd10);
    step();
    chk("fl_skid_full", {63'd0, id_a.ready}, 64'd0);
    chk("fl_pre_cnt", {48'd0, stall_a}, 64'd3);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'hE, 5'd11);
    step();
    chk("fl_ex_valid", {63'd0, ex_a.valid}, 64'd0);
    chk("fl_ex_wregen", {63'd0, ex_a.wregen}, 64'd0);
    chk("fl_ex_wmemen", {63'd0, ex_a.wmemen}, 64'd0);
    chk("fl_id_ready", {63'd0, id_a.ready}, 64'd1);
    chk("fl_cnt_held", {48'd0, stall_a}, 64'd3);
    chk("fl_payload_kept", {59'd0, ex_a.wreg1}, 64'd9);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 5'd0);
    ex_a.ready = 1'b1;
    step();
    chk("fl_discard_valid", {63'd0, ex_a.valid}, 64'd0);
    chk("fl_discard_wregen", {63'd0, ex_a.wregen}, 64'd0);
    chk("fl_discard_r1out", ex_a.r1out, 64'hC);

    // Saturation: 20 stalled cycles on a 4-bit counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    ex_a.ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 64'hF, 5'd4);
    step();
    chk("sat_start_b", {60'd0, stall_b}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step();
    end
    chk("sat_wide_cnt", {48'd0, stall_a}, 64'd20);
    chk("sat_narrow_cnt", {60'd0, stall_b}, 64'd15);
    step();
    step();
    chk("sat_narrow_hold", {60'd0, stall_b}, 64'd15);
    chk("sat_wide_more", {48'd0, stall_a}, 64'd22);
    chk("sat_ex_valid", {63'd0, ex_a.valid}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register. Carries decoded operands and control from the decode stage to the execute stage.
- Adds what the single-register stage lacks: a valid/ready handshake on both sides, a 2-entry skid buffer so id_ready is a register output, synchronous flush that inserts a bubble, and a saturating stall counter for performance monitoring.

Parameters:
- DATA_WIDTH, 64, width of each operand (r1out, r2out)
- REG_ADDR_WIDTH, 5, width of the destination register index
- ALUOP_WIDTH, 4, width of the ALU opcode
- STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight entries (branch/exception)
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage can accept; registered
- id_wregen  in  1  register write enable
- id_wmemen  in  1  memory write enable
- id_r1out  in  DATA_WIDTH  operand 1
- id_r2out  in  DATA_WIDTH  operand 2
- id_wreg1  in  REG_ADDR_WIDTH  destination register
- id_aluopcode  in  ALUOP_WIDTH  ALU operation
- ex_ready  in  1  execute stage accepts the current output
- ex_valid  out  1  output entry is valid
- ex_wregen  out  1  gated by ex_valid
- ex_wmemen  out  1  gated by ex_valid
- ex_r1out  out  DATA_WIDTH
- ex_r2out  out  DATA_WIDTH
- ex_wreg1  out  REG_ADDR_WIDTH
- ex_aluopcode  out  ALUOP_WIDTH
- stall_cnt  out  STALL_CNT_WIDTH  cycles with ex_valid=1 and ex_ready=0, saturating

Behaviour:
- Storage: main entry (drives ex_* outputs) and skid entry. Each has a valid bit plus a payload {wregen, wmemen, r1out, r2out, wreg1, aluopcode}.
- Handshakes:
  - Accept: id_valid && id_ready.
  - Issue: ex_valid && ex_ready.
- ex_valid = main_valid.
- ex_wregen = main_valid & main.wregen; ex_wmemen likewise. Enables are never 1 while ex_valid=0.
- id_ready is registered: it is 1 next cycle iff the skid entry will be empty next cycle. It is forced 0 while reset=1.
- Update rules, evaluated in priority order each rising edge:
  1. reset=1: both valid bits 0, all payload registers 0, stall_cnt 0. id_ready reads 0 during reset and 1 in the first cycle after reset.
  2. flush=1: both valid bits 0, so ex_valid=0 next cycle. Payload is unchanged, and any accept in the same cycle is discarded. stall_cnt is unchanged. id_ready is 1 next cycle.
  3. Otherwise:
     - Main empty or issuing, skid empty: accept loads main (latency 1 cycle, id to ex); no accept clears main_valid.
     - Main full and not issuing, accept occurs: the incoming entry goes to skid; id_ready drops next cycle.
     - Skid full and main issuing: skid moves to main and skid clears; id_ready rises next cycle.
     - Skid full and main not issuing: hold everything; id_ready stays 0.
- Order is preserved: the skid entry is always older than any new accept.
- Throughput: 1 entry/cycle while ex_ready=1 continuously. No bubble is introduced on a stall release.
- Data is never dropped or duplicated except by flush.
- stall_cnt: increments when ex_valid && !ex_ready and not flush/reset. It saturates at all-ones with no wrap.
- Payload widths are passed unmodified; no arithmetic is done on data.

Test Plan:
- Reset: hold reset 2 cycles with id_valid=1 -> ex_valid=0, all ex_* outputs 0, stall_cnt=0, id_ready=0 during reset and 1 in the cycle after.
- Streaming: ex_ready=1, push 4 entries with r1out=0x11..0x44 on consecutive cycles -> each appears on ex_r1out exactly 1 cycle later, ex_valid=1 for 4 consecutive cycles, id_ready stays 1.
- Stall: ex_ready=0 while pushing A (wreg1=3) then B (wreg1=7).
  - Required: id_ready=0 after B is accepted; ex_wreg1 holds 3.
  - Then raise ex_ready: ex_wreg1 shows 3 then 7 on consecutive cycles; id_ready returns to 1.
  - stall_cnt equals the number of stalled cycles.
- Flush with full skid: main and skid valid, assert flush with id_valid=1 -> next cycle ex_valid=0, ex_wregen=0, ex_wmemen=0, id_ready=1; the same-cycle input is discarded.
- Enable gating: load wregen=1, wmemen=1, then flush -> ex_wregen=0 and ex_wmemen=0 while ex_valid=0.
- Saturation: STALL_CNT_WIDTH=4, hold ex_valid=1 and ex_ready=0 for 20 cycles -> stall_cnt=15 and holds.
